// File: rtl/uart_fifo_ctrl_if.sv
// Signal bundle between the UART line logic / register block and the RX/TX FIFO controller.
// master drives characters, control and strobes; slave is the FIFO controller.
interface uart_fifo_ctrl_if #(
    parameter int unsigned CW = 5
);
    logic [1:0]    word_length;
    logic [2:0]    parity;
    logic          fifo_en;
    logic          rx_clr;
    logic          tx_clr;
    logic [1:0]    rx_trig;
    logic [8:0]    rx_data;
    logic          rx_valid;
    logic          rx_fe;
    logic          rx_bi;
    logic          rd_en;
    logic          lsr_rd;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          tx_ready;

    logic [7:0]    rx_dout;
    logic          rx_pe;
    logic          rx_fe_o;
    logic          rx_bi_o;
    logic          data_ready;
    logic          overrun_err;
    logic          fifo_err;
    logic          rx_trig_hit;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] tx_count;
    logic [8:0]    tx_data;
    logic          tx_valid;
    logic          thre;

    modport master (
        output word_length, parity, fifo_en, rx_clr, tx_clr, rx_trig,
               rx_data, rx_valid, rx_fe, rx_bi, rd_en, lsr_rd,
               wr_data, wr_en, tx_ready,
        input  rx_dout, rx_pe, rx_fe_o, rx_bi_o, data_ready, overrun_err,
               fifo_err, rx_trig_hit, rx_count, tx_count, tx_data, tx_valid, thre
    );

    modport slave (
        input  word_length, parity, fifo_en, rx_clr, tx_clr, rx_trig,
               rx_data, rx_valid, rx_fe, rx_bi, rd_en, lsr_rd,
               wr_data, wr_en, tx_ready,
        output rx_dout, rx_pe, rx_fe_o, rx_bi_o, data_ready, overrun_err,
               fifo_err, rx_trig_hit, rx_count, tx_count, tx_data, tx_valid, thre
    );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// 16550-style RX/TX character FIFOs: parity check/generation, overrun, error tracking and RX trigger.
// Head entries are presented first-word-fall-through from registered copies of the next head.
module uart_fifo_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_fifo_ctrl_if.slave bus
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned RW  = 11;
    localparam logic [CW-1:0] CAP = CW'(DEPTH);

    logic            pen, eps, sp;
    logic [7:0]      char_mask;
    logic [8:0]      par_sel;
    logic            fifo_en_q, mode_chg;

    logic [RW-1:0]   rx_mem [DEPTH];
    logic [AW-1:0]   rx_wr, rx_rd, rx_wr_n, rx_rd_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n, rx_ecnt, rx_ecnt_n, rx_level;
    logic [RW-1:0]   rx_entry, rx_head_n;
    logic [7:0]      rx_char;
    logic            rx_p, rx_dp, rx_perr;
    logic            rx_flush, rx_full, rx_push, rx_pop, rx_ovr_set, push_err, pop_err, ovr_n;

    logic [8:0]      tx_mem [DEPTH];
    logic [AW-1:0]   tx_wr, tx_rd, tx_wr_n, tx_rd_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [8:0]      tx_entry, tx_head_n;
    logic [7:0]      tx_char;
    logic            tx_par, tx_flush, tx_full, tx_push, tx_xfer;

    assign {sp, eps, pen} = bus.parity;
    assign par_sel        = 9'h020 << bus.word_length;
    assign mode_chg       = bus.fifo_en ^ fifo_en_q;

    always_comb begin
        char_mask = 8'hFF;
        unique case (bus.word_length)
            2'd0:    char_mask = 8'h1F;
            2'd1:    char_mask = 8'h3F;
            2'd2:    char_mask = 8'h7F;
            default: char_mask = 8'hFF;
        endcase
    end

    // Received parity check; stick parity expects the complement of EPS on the line
    assign rx_char  = bus.rx_data[7:0] & char_mask;
    assign rx_dp    = ^rx_char;
    assign rx_p     = |(bus.rx_data & par_sel);
    assign rx_perr  = pen & (sp ? (rx_p != ~eps) : (rx_dp ^ rx_p ^ ~eps));
    assign rx_entry = {rx_char, rx_perr, bus.rx_fe, bus.rx_bi};
    assign rx_flush = bus.rx_clr | mode_chg;

    // Transmit parity is frozen into the entry at push time
    assign tx_char  = bus.wr_data & char_mask;
    assign tx_par   = sp ? ~eps : (eps ? ^tx_char : ~^tx_char);
    assign tx_entry = {1'b0, tx_char} | ({9{pen & tx_par}} & par_sel);
    assign tx_flush = bus.tx_clr | mode_chg;

    always_comb begin
        rx_level = CW'(1);
        if (bus.fifo_en) begin
            unique case (bus.rx_trig)
                2'd0:    rx_level = CW'(1);
                2'd1:    rx_level = CW'(DEPTH / 4);
                2'd2:    rx_level = CW'(DEPTH / 2);
                default: rx_level = CW'(DEPTH - 2);
            endcase
        end
    end

    // RX next state: a pop frees the slot a coincident push needs, so full+push+pop is legal
    always_comb begin
        rx_full    = bus.fifo_en ? (rx_cnt == CAP) : (rx_cnt != '0);
        rx_pop     = bus.rd_en & (rx_cnt != '0) & ~rx_flush;
        rx_push    = bus.rx_valid & ~rx_flush & (~rx_full | rx_pop);
        rx_ovr_set = bus.rx_valid & ~rx_flush & rx_full & ~rx_pop;
        push_err   = rx_push & (rx_perr | bus.rx_fe | bus.rx_bi);
        pop_err    = rx_pop & (|rx_mem[rx_rd][2:0]);
        ovr_n      = rx_ovr_set | (bus.overrun_err & ~bus.lsr_rd);
        rx_wr_n    = rx_wr;
        rx_rd_n    = rx_rd;
        rx_cnt_n   = rx_cnt;
        rx_ecnt_n  = rx_ecnt;
        if (rx_flush) begin
            rx_wr_n   = '0;
            rx_rd_n   = '0;
            rx_cnt_n  = '0;
            rx_ecnt_n = '0;
        end else begin
            if (rx_push) rx_wr_n = rx_wr + AW'(1);
            if (rx_pop)  rx_rd_n = rx_rd + AW'(1);
            if (rx_push && !rx_pop)      rx_cnt_n = rx_cnt + CW'(1);
            else if (rx_pop && !rx_push) rx_cnt_n = rx_cnt - CW'(1);
            rx_ecnt_n = rx_ecnt + CW'(push_err) - CW'(pop_err);
        end
        if (rx_cnt_n == '0)                      rx_head_n = '0;
        else if (rx_push && (rx_wr == rx_rd_n))  rx_head_n = rx_entry;
        else                                     rx_head_n = rx_mem[rx_rd_n];
    end

    always_comb begin
        tx_full  = bus.fifo_en ? (tx_cnt == CAP) : (tx_cnt != '0);
        tx_xfer  = bus.tx_ready & (tx_cnt != '0) & ~tx_flush;
        tx_push  = bus.wr_en & ~tx_flush & (~tx_full | tx_xfer);
        tx_wr_n  = tx_wr;
        tx_rd_n  = tx_rd;
        tx_cnt_n = tx_cnt;
        if (tx_flush) begin
            tx_wr_n  = '0;
            tx_rd_n  = '0;
            tx_cnt_n = '0;
        end else begin
            if (tx_push) tx_wr_n = tx_wr + AW'(1);
            if (tx_xfer) tx_rd_n = tx_rd + AW'(1);
            if (tx_push && !tx_xfer)      tx_cnt_n = tx_cnt + CW'(1);
            else if (tx_xfer && !tx_push) tx_cnt_n = tx_cnt - CW'(1);
        end
        if (tx_cnt_n == '0)                      tx_head_n = '0;
        else if (tx_push && (tx_wr == tx_rd_n))  tx_head_n = tx_entry;
        else                                     tx_head_n = tx_mem[tx_rd_n];
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr] <= rx_entry;
        if (tx_push) tx_mem[tx_wr] <= tx_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_en_q       <= 1'b0;
            rx_wr           <= '0;
            rx_rd           <= '0;
            rx_cnt          <= '0;
            rx_ecnt         <= '0;
            tx_wr           <= '0;
            tx_rd           <= '0;
            tx_cnt          <= '0;
            bus.rx_dout     <= '0;
            bus.rx_pe       <= 1'b0;
            bus.rx_fe_o     <= 1'b0;
            bus.rx_bi_o     <= 1'b0;
            bus.data_ready  <= 1'b0;
            bus.overrun_err <= 1'b0;
            bus.fifo_err    <= 1'b0;
            bus.rx_trig_hit <= 1'b0;
            bus.tx_data     <= '0;
            bus.tx_valid    <= 1'b0;
            bus.thre        <= 1'b1;
        end else begin
            fifo_en_q       <= bus.fifo_en;
            rx_wr           <= rx_wr_n;
            rx_rd           <= rx_rd_n;
            rx_cnt          <= rx_cnt_n;
            rx_ecnt         <= rx_ecnt_n;
            tx_wr           <= tx_wr_n;
            tx_rd           <= tx_rd_n;
            tx_cnt          <= tx_cnt_n;
            bus.rx_dout     <= rx_head_n[10:3];
            bus.rx_pe       <= rx_head_n[2];
            bus.rx_fe_o     <= rx_head_n[1];
            bus.rx_bi_o     <= rx_head_n[0];
            bus.data_ready  <= rx_cnt_n != '0;
            bus.overrun_err <= ovr_n;
            bus.fifo_err    <= bus.fifo_en & (rx_ecnt_n != '0);
            bus.rx_trig_hit <= rx_cnt_n >= rx_level;
            bus.tx_data     <= tx_head_n;
            bus.tx_valid    <= tx_cnt_n != '0;
            bus.thre        <= tx_cnt_n == '0;
        end
    end

    assign bus.rx_count = rx_cnt;
    assign bus.tx_count = tx_cnt;
endmodule
